// File: rtl/inst_mem_resp.sv
// inst_mem_resp: fixed-latency instruction fetch responder with loader write port and flush.
module inst_mem_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ce,
  input  logic [31:0]       inst_addr,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       inst_rdata,
  output logic              inst_valid,
  output logic              inst_err,
  output logic [2:0]        inflight
);
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("inst_mem_resp: LATENCY must be in 1..4");
  end
  logic [31:0]       mem [2**ADDR_W];
  logic [LATENCY-1:0] v, e;
  logic [31:0]       d [LATENCY];
  logic [ADDR_W-1:0] idx;
  logic              bad;
  assign idx = inst_addr[ADDR_W+1:2];
  assign bad = (|inst_addr[1:0]) || (|inst_addr[31:ADDR_W+2]);
  always_ff @(posedge clk)
    if (ld_we) mem[ld_addr] <= ld_data;
  // Stage data only moves with a valid entry so the output holds its last response.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v        <= '0;
      e        <= '0;
      inflight <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= inst_ce;
      if (inst_ce) begin
        e[0] <= bad;
        d[0] <= bad ? 32'h0 : mem[idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1] & ~flush;
        if (v[i-1] && !flush) begin
          e[i] <= e[i-1];
          d[i] <= d[i-1];
        end
      end
      inflight <= (flush ? 3'd0 : inflight - {2'b0, v[LATENCY-1]}) + {2'b0, inst_ce};
    end
  assign inst_valid = v[LATENCY-1];
  assign inst_err   = v[LATENCY-1] & e[LATENCY-1];
  assign inst_rdata = d[LATENCY-1];
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed checks of inst_mem_resp at LATENCY=1 and LATENCY=3.
module tb_inst_mem_resp;
  logic        clk = 0, rst = 1, inst_ce = 0, flush = 0, ld_we = 0;
  logic [31:0] inst_addr = 0, ld_data = 0;
  logic [9:0]  ld_addr = 0;
  logic [31:0] r1, r3;
  logic        v1, v3, e1, e3;
  logic [2:0]  f1, f3;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  inst_mem_resp #(.ADDR_W(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .inst_ce(inst_ce), .inst_addr(inst_addr), .flush(flush),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .inst_rdata(r1), .inst_valid(v1), .inst_err(e1), .inflight(f1));
  inst_mem_resp #(.ADDR_W(10), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .inst_ce(inst_ce), .inst_addr(inst_addr), .flush(flush),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .inst_rdata(r3), .inst_valid(v3), .inst_err(e3), .inflight(f3));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    inst_ce = 0;
    flush = 0;
    ld_we = 0;
    repeat (n) @(negedge clk);
  endtask
  int n;
  logic [31:0] last;
  initial begin
    repeat (2) @(negedge clk);
    chk("rst v1", v1, 0); chk("rst e1", e1, 0); chk("rst f1", f1, 0); chk("rst r1", r1, 0);
    chk("rst v3", v3, 0); chk("rst f3", f3, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      ld_we = 1; ld_addr = 10'(i); ld_data = 32'h11 * (i + 1);
      @(negedge clk);
    end
    ld_we = 0;
    // Test 1: back-to-back fetches at LATENCY=1
    for (int i = 0; i < 4; i++) begin
      inst_ce = 1; inst_addr = 32'(4 * i);
      @(negedge clk);
      chk("t1 valid", v1, 1); chk("t1 data", r1, 32'h11 * (i + 1)); chk("t1 err", e1, 0);
    end
    idle(1);
    chk("t1 valid low", v1, 0);
    idle(4);
    // Test 2: single fetch at LATENCY=3
    inst_ce = 1; inst_addr = 32'h8;
    @(negedge clk);
    inst_ce = 0;
    chk("t2 f c1", f3, 1); chk("t2 v c1", v3, 0);
    @(negedge clk);
    chk("t2 f c2", f3, 1); chk("t2 v c2", v3, 0);
    @(negedge clk);
    chk("t2 f c3", f3, 1); chk("t2 v c3", v3, 1); chk("t2 data", r3, 32'h33);
    @(negedge clk);
    chk("t2 f c4", f3, 0); chk("t2 v c4", v3, 0);
    idle(4);
    // Test 3: misaligned and out-of-range fetches
    inst_ce = 1; inst_addr = 32'h6;
    @(negedge clk);
    chk("t3 mis v", v1, 1); chk("t3 mis err", e1, 1); chk("t3 mis data", r1, 0);
    inst_addr = 32'h0000_1000;
    @(negedge clk);
    chk("t3 oor v", v1, 1); chk("t3 oor err", e1, 1); chk("t3 oor data", r1, 0);
    inst_addr = 32'h4;
    @(negedge clk);
    chk("t3 ok err", e1, 0); chk("t3 ok data", r1, 32'h22);
    idle(1);
    chk("t3 l3 err", e3, 1); chk("t3 l3 data", r3, 0);
    idle(4);
    // Test 4: flush with the third of three fetches at LATENCY=3
    for (int i = 0; i < 3; i++) begin
      inst_ce = 1; inst_addr = 32'(4 * i); flush = (i == 2);
      @(negedge clk);
      chk("t4 no early v", v3, 0);
    end
    chk("t4 inflight", f3, 1);
    n = 0; last = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (v3) begin n++; last = r3; end
    end
    chk("t4 count", n, 1); chk("t4 data", last, 32'h33); chk("t4 f end", f3, 0);
    // Test 5: same-edge load and fetch of word 1
    ld_we = 1; ld_addr = 10'd1; ld_data = 32'hAA; inst_ce = 1; inst_addr = 32'h4;
    @(negedge clk);
    ld_we = 0;
    chk("t5 old", r1, 32'h22);
    @(negedge clk);
    chk("t5 new", r1, 32'hAA);
    idle(4);
    // Test 6: async reset with two fetches in flight
    inst_ce = 1; inst_addr = 32'h0;
    @(negedge clk);
    inst_addr = 32'h4;
    @(negedge clk);
    inst_ce = 0;
    chk("t6 pre f3", f3, 2);
    #2 rst = 1;
    #1;
    chk("t6 v1", v1, 0); chk("t6 r1", r1, 0); chk("t6 f1", f1, 0);
    chk("t6 v3", v3, 0); chk("t6 e3", e3, 0); chk("t6 f3", f3, 0); chk("t6 r3", r3, 0);
    @(negedge clk);
    rst = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (v1 || v3) n++;
    end
    chk("t6 stale", n, 0);
    inst_ce = 1; inst_addr = 32'h0;
    @(negedge clk);
    inst_ce = 0;
    chk("t6 l1 v", v1, 1); chk("t6 l1 data", r1, 32'h11);
    idle(2);
    chk("t6 l3 v", v3, 1); chk("t6 l3 data", r3, 32'h11);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
Instruction-memory responder at the fetch end of the PC interface. It accepts a byte fetch address plus a chip-enable every cycle and returns the addressed 32-bit word after a fixed, parameterised latency, with a valid flag and an error flag. It also provides a loader write port for filling the program image, and a flush input that kills in-flight fetches on redirect.

Parameters:
ADDR_W, 10, word-index width; depth is 2^ADDR_W words (4 KiB at default).
LATENCY, 1, cycles from request to response; legal range 1..4.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; asynchronous, active-high; clears the response pipeline.
inst_ce  in  1  fetch request enable; may be held high every cycle.
inst_addr  in  32  byte fetch address (the PC value).
flush  in  1  kills every fetch still in flight; the same-cycle request is kept.
ld_we  in  1  loader write enable.
ld_addr  in  ADDR_W  loader word index.
ld_data  in  32  loader write data.
inst_rdata  out  32  fetched instruction.
inst_valid  out  1  inst_rdata/inst_err are valid this cycle.
inst_err  out  1  response belongs to a misaligned or out-of-range fetch.
inflight  out  3  count of accepted, not-yet-returned, not-killed requests.

Behaviour:
- Reset (async, rst=1): inst_valid=0, inst_err=0, inst_rdata=0, inflight=0, all pipeline stages invalid. Memory contents are not cleared. A reset mid-operation discards every in-flight fetch.
- Request accepted on any rising edge with inst_ce=1 and rst=0. No back-pressure; one request per cycle.
- Word index = inst_addr[ADDR_W+1:2].
- Misaligned fetch (inst_addr[1:0]!=0) or out-of-range fetch (any of inst_addr[31:ADDR_W+2]!=0): response has inst_rdata=0x00000000 and inst_err=1. Memory is not read.
- Latency: a request accepted on edge N produces inst_valid=1 during the cycle after edge N+LATENCY-1. LATENCY=1 gives registered-read timing: data appears the cycle after the request.
- Responses are returned in request order, one per accepted request. inst_valid is low on cycles with no response due.
- Pipeline: LATENCY stages, each holding {valid, err, data or index}. Array read happens in stage 1; later stages only delay.
- flush=1 on edge N clears the valid bit of every stage holding a request accepted before edge N. A request with inst_ce=1 on the same edge is accepted normally.
- inflight: +1 per accepted request, -1 per response. Flush sets it to 1 if a request was accepted on that edge, else 0. Saturation is unnecessary (max LATENCY).
- Loader write: ld_we=1 writes ld_data to mem[ld_addr] on the edge. It is independent of fetch.
- Same-edge read and write to the same word: read-before-write; the fetch returns the old data and the next fetch returns the new data.
- inst_rdata holds its last value when inst_valid=0. The bench checks it only when inst_valid=1.
- Parameter check: LATENCY outside 1..4 triggers an elaboration-time error.

Test Plan:
1. Reset, load mem[0..3]=0x11,0x22,0x33,0x44 via the loader, then fetch 0x0,0x4,0x8,0xC back-to-back at LATENCY=1 -> inst_valid high for 4 consecutive cycles starting the cycle after the first request; data 0x11,0x22,0x33,0x44; inst_err=0.
2. LATENCY=3: single fetch of 0x8 -> inst_valid rises exactly 3 cycles after the request with 0x33; inflight goes 1,1,1,0.
3. Fetch 0x6 and 0x00001000 (ADDR_W=10) -> two responses, each with inst_rdata=0 and inst_err=1; the next fetch of 0x4 returns 0x22 with inst_err=0.
4. LATENCY=3: fetch 0x0,0x4,0x8 on consecutive edges, with flush asserted together with the third -> only one response (0x33); inflight=1 right after the flush edge.
5. Same edge: ld_we to word 1 with 0xAA and fetch 0x4 -> response 0x22; fetch 0x4 again -> 0xAA.
6. rst asserted asynchronously mid-burst with 2 fetches in flight -> inst_valid, inst_err, inflight and inst_rdata go to 0 immediately; no stale response after release; memory still returns 0x11 at 0x0.
